adc_cap_scan_seq: RTL and testbench

//  Multi-channel sequencer for the 5V ADC input sampling capacitors (GNDAD/GNDADR-referenced cap cells).
//  Per enabled channel: discharge cap to GNDAD, sample ADINx onto it, then handshake one conversion with the ADC core.

---
 rtl/adc_cap_pkg.sv | 17 +
 rtl/adc_cap_prio_enc.sv | 23 ++
 rtl/adc_cap_scan_seq.sv | 164 ++++++++++++++++
 tb/tb_adc_cap_scan_seq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_cap_pkg.sv
// Shared types and constants for the ADC sampling-capacitor scan sequencer.
package adc_cap_pkg;

    localparam int unsigned NCH_MAX = 16;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        StIdle,
        StSel,
        StDis,
        StGap1,
        StSmp,
        StGap2,
        StHold
    } state_e;

endpackage

// File: rtl/adc_cap_prio_enc.sv
// Lowest-set-bit priority encoder: returns index of the lowest requesting bit.
module adc_cap_prio_enc #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         valid
);

    // Scan from the top so the lowest set bit wins the last assignment.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = W'(i);
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/adc_cap_scan_seq.sv
// Per-channel discharge / sample / convert sequencer for the ADC input sampling caps.
module adc_cap_scan_seq
    import adc_cap_pkg::*;
#(
    parameter int unsigned NCH  = 8,
    parameter int unsigned CNTW = 8,
    parameter int unsigned CHW  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            cont,
    input  logic [NCH-1:0]  ch_mask,
    input  logic [CNTW-1:0] dis_cyc,
    input  logic [CNTW-1:0] smp_cyc,
    input  logic            conv_ack,
    output logic [NCH-1:0]  dis_en,
    output logic [NCH-1:0]  smp_en,
    output logic            conv_req,
    output logic [CHW-1:0]  ch_id,
    output logic            busy,
    output logic            done
);

    localparam logic [CNTW-1:0] CntOne = CNTW'(1);
    localparam logic [NCH-1:0]  BitOne = NCH'(1);

    state_e          state_q, state_d;
    logic [NCH-1:0]  mask_q, mask_d;
    logic [NCH-1:0]  mask_lat_q, mask_lat_d;
    logic            cont_q, cont_d;
    logic [CNTW-1:0] dis_cyc_q, dis_cyc_d;
    logic [CNTW-1:0] smp_cyc_q, smp_cyc_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CHW-1:0]  ch_id_q, ch_id_d;
    logic            done_q, done_d;

    logic [CHW-1:0]  enc_idx;
    logic            enc_valid;
    logic [CNTW-1:0] dis_load, smp_load;
    logic [NCH-1:0]  ch_onehot;

    adc_cap_prio_enc #(
        .N (NCH),
        .W (CHW)
    ) u_prio_enc (
        .req   (mask_q),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    assign dis_load = (dis_cyc_q == '0) ? CntOne : dis_cyc_q;
    assign smp_load = (smp_cyc_q == '0) ? CntOne : smp_cyc_q;

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        mask_lat_d = mask_lat_q;
        cont_d     = cont_q;
        dis_cyc_d  = dis_cyc_q;
        smp_cyc_d  = smp_cyc_q;
        cnt_d      = cnt_q;
        ch_id_d    = ch_id_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && (ch_mask != '0)) begin
                    mask_d     = ch_mask;
                    mask_lat_d = ch_mask;
                    cont_d     = cont;
                    dis_cyc_d  = dis_cyc;
                    smp_cyc_d  = smp_cyc;
                    state_d    = StSel;
                end
            end
            StSel: begin
                if (enc_valid) begin
                    ch_id_d = enc_idx;
                    mask_d  = mask_q & ~(BitOne << enc_idx);
                    cnt_d   = dis_load;
                    state_d = StDis;
                end else begin
                    state_d = StIdle;
                end
            end
            StDis: begin
                if (cnt_q <= CntOne) begin
                    state_d = StGap1;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StGap1: begin
                cnt_d   = smp_load;
                state_d = StSmp;
            end
            StSmp: begin
                if (cnt_q <= CntOne) begin
                    state_d = StGap2;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StGap2: begin
                state_d = StHold;
            end
            StHold: begin
                if (conv_ack) begin
                    if (mask_q != '0) begin
                        state_d = StSel;
                    end else if (cont_q) begin
                        mask_d  = mask_lat_q;
                        state_d = StSel;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort) begin
            state_d = StIdle;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            mask_q     <= '0;
            mask_lat_q <= '0;
            cont_q     <= 1'b0;
            dis_cyc_q  <= '0;
            smp_cyc_q  <= '0;
            cnt_q      <= '0;
            ch_id_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            mask_lat_q <= mask_lat_d;
            cont_q     <= cont_d;
            dis_cyc_q  <= dis_cyc_d;
            smp_cyc_q  <= smp_cyc_d;
            cnt_q      <= cnt_d;
            ch_id_q    <= ch_id_d;
            done_q     <= done_d;
        end
    end

    // Switch enables decode straight from state so reset opens them without a clock.
    assign ch_onehot = BitOne << ch_id_q;
    assign dis_en    = (state_q == StDis) ? ch_onehot : '0;
    assign smp_en    = (state_q == StSmp) ? ch_onehot : '0;
    assign conv_req  = (state_q == StHold);
    assign busy      = (state_q != StIdle);
    assign ch_id     = ch_id_q;
    assign done      = done_q;

endmodule

// File: tb/tb_adc_cap_scan_seq.sv
// Scoreboard bench for adc_cap_scan_seq: expected conversions/DONEs queued, monitor pops and checks.
module tb_adc_cap_scan_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       cont = 1'b0;
    logic [7:0] ch_mask = '0;
    logic [7:0] dis_cyc = '0;
    logic [7:0] smp_cyc = '0;
    logic       conv_ack;
    logic [7:0] dis_en;
    logic [7:0] smp_en;
    logic       conv_req;
    logic [2:0] ch_id;
    logic       busy;
    logic       done;

    logic ack_pulse = 1'b0;
    logic ack_force = 1'b0;
    int   ack_delay = 2;

    assign conv_ack = ack_pulse | ack_force;

    adc_cap_scan_seq #(
        .NCH  (8),
        .CNTW (8),
        .CHW  (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .cont     (cont),
        .ch_mask  (ch_mask),
        .dis_cyc  (dis_cyc),
        .smp_cyc  (smp_cyc),
        .conv_ack (conv_ack),
        .dis_en   (dis_en),
        .smp_en   (smp_en),
        .conv_req (conv_req),
        .ch_id    (ch_id),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int ch;
        int dis;
        int smp;
        int req;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_conv(input int ch, input int d, input int s);
        exp_t e;
        e.is_done = 1'b0;
        e.ch      = ch;
        e.dis     = (d == 0) ? 1 : d;
        e.smp     = (s == 0) ? 1 : s;
        e.req     = ack_delay + 1;
        q.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1;
        e.ch      = 0;
        e.dis     = 0;
        e.smp     = 0;
        e.req     = 0;
        q.push_back(e);
    endtask

    task automatic pulse_start(input logic [7:0] m, input bit c, input logic [7:0] d,
                               input logic [7:0] s);
        @(posedge clk);
        #1;
        start   = 1'b1;
        ch_mask = m;
        cont    = c;
        dis_cyc = d;
        smp_cyc = s;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Queue the one-shot expectations for a mask, then issue the START pulse.
    task automatic scan(input logic [7:0] m, input logic [7:0] d, input logic [7:0] s);
        for (int i = 0; i < 8; i++) begin
            if (m[i]) push_conv(i, int'(d), int'(s));
        end
        push_done();
        pulse_start(m, 1'b0, d, s);
    endtask

    task automatic wait_sig(input int sel, input string what);
        bit hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0:       hit = (dis_en != '0);
                1:       hit = (smp_en != '0);
                3:       hit = !busy;
                4:       hit = smp_en[1];
                5:       hit = !smp_en[1];
                default: hit = 1'b1;
            endcase
        end
        if (!hit) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout_%s: event not seen within 2000 cycles", what);
        end
    endtask

    // ADC core model: acknowledge ack_delay cycles after the request appears.
    always begin
        wait (conv_req === 1'b1);
        repeat (ack_delay) @(posedge clk);
        #1 ack_pulse = 1'b1;
        @(posedge clk);
        #1 ack_pulse = 1'b0;
    end

    int         dis_cnt = 0, smp_cnt = 0, req_cnt = 0;
    logic [7:0] dis_vec = '0, smp_vec = '0;
    logic [2:0] req_ch = '0;
    bit         prev_req = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            dis_cnt  = 0;
            smp_cnt  = 0;
            req_cnt  = 0;
            prev_req = 1'b0;
        end else begin
            chk("break_before_make", 32'(((dis_en & smp_en) != '0) ||
                (conv_req && ((dis_en | smp_en) != '0))), 32'd0);
            if (dis_en != '0) begin
                dis_cnt++;
                dis_vec = dis_en;
            end
            if (smp_en != '0) begin
                smp_cnt++;
                smp_vec = smp_en;
            end
            if (conv_req) begin
                req_cnt++;
                req_ch = ch_id;
            end
            if (prev_req && !conv_req) begin
                if (q.size() == 0 || q[0].is_done) begin
                    chk("unexpected_conversion", {29'd0, req_ch}, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("ch_id", {29'd0, req_ch}, e.ch);
                    chk("dis_en_onehot", {24'd0, dis_vec}, 32'd1 << e.ch);
                    chk("smp_en_onehot", {24'd0, smp_vec}, 32'd1 << e.ch);
                    chk("dis_cycles", dis_cnt, e.dis);
                    chk("smp_cycles", smp_cnt, e.smp);
                    chk("req_cycles", req_cnt, e.req);
                end
                dis_cnt = 0;
                smp_cnt = 0;
                req_cnt = 0;
            end
            if (done) begin
                if (q.size() == 0 || !q[0].is_done) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("done_pulse", {31'd0, done}, 32'd1);
                end
            end
            if (!busy) begin
                dis_cnt = 0;
                smp_cnt = 0;
                req_cnt = 0;
            end
            prev_req = conv_req;
        end
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", {8'd0, dis_en, smp_en, conv_req, ch_id, busy, done}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_idle", {8'd0, dis_en, smp_en, conv_req, ch_id, busy, done}, 32'd0);

        // Two channels, DONE once
        ack_delay = 2;
        scan(8'b0000_0101, 8'd3, 8'd4);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        wait_sig(3, "scan1");
        @(negedge clk);

        // Zero durations treated as one cycle, top channel
        scan(8'h80, 8'd0, 8'd0);
        wait_sig(3, "scan2");
        @(negedge clk);

        // START mid-scan ignored, including its mask and CONT
        scan(8'h06, 8'd2, 8'd2);
        wait_sig(0, "scan4_dis");
        pulse_start(8'hFF, 1'b1, 8'd5, 8'd5);
        wait_sig(3, "scan4");
        @(negedge clk);
        pulse_start(8'h00, 1'b0, 8'd2, 8'd2);
        repeat (2) @(negedge clk);
        chk("empty_mask_no_busy", {31'd0, busy}, 32'd0);

        // ACK held during DIS/SMP ignored; long ACK latency
        ack_delay = 99;
        scan(8'h08, 8'd2, 8'd3);
        wait_sig(0, "scan5_dis");
        ack_force = 1'b1;
        wait_sig(1, "scan5_smp");
        wait_sig(6, "scan5_step");
        while (smp_en != '0) @(negedge clk);
        ack_force = 1'b0;
        wait_sig(3, "scan5");
        @(negedge clk);

        // Continuous scan, ABORT in second SMP of ch1
        ack_delay = 1;
        push_conv(0, 2, 2);
        push_conv(1, 2, 2);
        push_conv(0, 2, 2);
        pulse_start(8'h03, 1'b1, 8'd2, 8'd2);
        wait_sig(4, "cont_smp1_a");
        wait_sig(5, "cont_smp1_b");
        wait_sig(4, "cont_smp1_c");
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_outputs", {14'd0, dis_en, smp_en, conv_req, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_stays_idle", {31'd0, busy}, 32'd0);

        // Async reset mid-SMP, then a normal restart
        pulse_start(8'h10, 1'b0, 8'd2, 8'd3);
        wait_sig(1, "rst_smp");
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_opens", {14'd0, dis_en, smp_en, conv_req, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ack_delay = 2;
        scan(8'h10, 8'd2, 8'd3);
        wait_sig(3, "restart");
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
